// File: rtl/pipeline_ctrl_pkg.sv
// Shared constants and types for the pipeline hazard/sequencing controller.
//   STALL_*      : stall vector encodings ([0] PC, [1] IF_ID, [2] ID_EX+EX_MEM)
//   STALL_MASK_* : single-bit masks into the stall vector
//   state_e      : controller state codes
package pipeline_ctrl_pkg;

  localparam logic [2:0] STALL_NONE  = 3'b000;
  localparam logic [2:0] STALL_FETCH = 3'b001;
  localparam logic [2:0] STALL_LDUSE = 3'b011;
  localparam logic [2:0] STALL_ALL   = 3'b111;

  localparam logic [2:0] STALL_MASK_PC    = 3'b001;
  localparam logic [2:0] STALL_MASK_IF_ID = 3'b010;
  localparam logic [2:0] STALL_MASK_ID_EX = 3'b100;

  typedef enum logic [1:0] {
    ST_RUN     = 2'd0,
    ST_LDUSE   = 2'd1,
    ST_MEMWAIT = 2'd2,
    ST_FLUSH   = 2'd3
  } state_e;

endpackage

// File: rtl/pipeline_hazard_detect.sv
// Combinational load-use hazard compare.
//   ex_is_load, ex_rd_addr         : load in EX and its destination
//   id_r*_addr, id_r*_used         : ID source registers and their use flags
//   hazard                         : ID needs the EX load result next cycle
module pipeline_hazard_detect (
  input  logic       ex_is_load,
  input  logic [4:0] ex_rd_addr,
  input  logic [4:0] id_r1_addr,
  input  logic [4:0] id_r2_addr,
  input  logic       id_r1_used,
  input  logic       id_r2_used,
  output logic       hazard
);

  logic r1_hit, r2_hit;

  assign r1_hit = id_r1_used && (id_r1_addr == ex_rd_addr);
  assign r2_hit = id_r2_used && (id_r2_addr == ex_rd_addr);

  // x0 is hardwired zero, so a load targeting it never creates a dependency.
  assign hazard = ex_is_load && (ex_rd_addr != 5'd0) && (r1_hit || r2_hit);

endmodule

// File: rtl/pipeline_ctrl.sv
// Central hazard/sequencing controller for the 5-stage pipeline.
//   clk_in, rst_in (async, active-low)
//   rdy_in, mem_busy, if_busy, branch_taken : global/stage status
//   ex_is_load, ex_rd_addr, id_r*_addr/used : load-use inputs
//   stall[2:0], clear_if_id, clear_id_ex    : Mealy pipeline controls
//   stall_cycles, flush_count               : saturating event counters
module pipeline_ctrl
  import pipeline_ctrl_pkg::*;
#(
  parameter int CNT_W = 32
) (
  input  logic             clk_in,
  input  logic             rst_in,
  input  logic             rdy_in,
  input  logic             mem_busy,
  input  logic             if_busy,
  input  logic             branch_taken,
  input  logic             ex_is_load,
  input  logic [4:0]       ex_rd_addr,
  input  logic [4:0]       id_r1_addr,
  input  logic [4:0]       id_r2_addr,
  input  logic             id_r1_used,
  input  logic             id_r2_used,
  output logic [2:0]       stall,
  output logic             clear_if_id,
  output logic             clear_id_ex,
  output logic [CNT_W-1:0] stall_cycles,
  output logic [CNT_W-1:0] flush_count
);

  state_e           state_q, state_d;
  logic             pend_q, pend_d;
  logic [CNT_W-1:0] stall_cnt_q, stall_cnt_d;
  logic [CNT_W-1:0] flush_cnt_q, flush_cnt_d;

  logic       hazard;
  logic       br_eff;
  logic [2:0] stall_c;
  logic       clr_if_c, clr_ex_c, flush_evt;

  pipeline_hazard_detect u_hazard (
    .ex_is_load (ex_is_load),
    .ex_rd_addr (ex_rd_addr),
    .id_r1_addr (id_r1_addr),
    .id_r2_addr (id_r2_addr),
    .id_r1_used (id_r1_used),
    .id_r2_used (id_r2_used),
    .hazard     (hazard)
  );

  // A branch resolved while memory was busy is replayed on MEMWAIT exit.
  assign br_eff = branch_taken || ((state_q == ST_MEMWAIT) && pend_q);

  always_comb begin
    state_d   = state_q;
    pend_d    = pend_q;
    stall_c   = STALL_NONE;
    clr_if_c  = 1'b0;
    clr_ex_c  = 1'b0;
    flush_evt = 1'b0;
    if (!rdy_in) begin
      stall_c = STALL_ALL;
    end else if (mem_busy) begin
      stall_c = STALL_ALL;
      state_d = ST_MEMWAIT;
      if (branch_taken) pend_d = 1'b1;
    end else begin
      pend_d = 1'b0;
      if (state_q == ST_FLUSH) begin
        // Discard the wrong-path fetch still in flight; no load-use here.
        if (if_busy) begin
          stall_c  = STALL_FETCH;
          clr_if_c = 1'b1;
        end else begin
          state_d = ST_RUN;
        end
      end else if (br_eff) begin
        clr_if_c  = 1'b1;
        clr_ex_c  = 1'b1;
        flush_evt = 1'b1;
        state_d   = ST_FLUSH;
      end else if (hazard && (state_q != ST_LDUSE)) begin
        // LDUSE lasts one cycle: the load has moved to MEM and forwards.
        stall_c  = STALL_LDUSE;
        clr_ex_c = 1'b1;
        state_d  = ST_LDUSE;
      end else begin
        state_d = ST_RUN;
      end
    end
  end

  always_comb begin
    stall_cnt_d = stall_cnt_q;
    flush_cnt_d = flush_cnt_q;
    if (rdy_in && (stall_c != STALL_NONE) && (stall_cnt_q != '1))
      stall_cnt_d = stall_cnt_q + 1'b1;
    if (flush_evt && (flush_cnt_q != '1))
      flush_cnt_d = flush_cnt_q + 1'b1;
  end

  always_ff @(posedge clk_in or negedge rst_in) begin
    if (!rst_in) begin
      state_q     <= ST_RUN;
      pend_q      <= 1'b0;
      stall_cnt_q <= '0;
      flush_cnt_q <= '0;
    end else begin
      state_q     <= state_d;
      pend_q      <= pend_d;
      stall_cnt_q <= stall_cnt_d;
      flush_cnt_q <= flush_cnt_d;
    end
  end

  // Hold the whole pipe and squash both latches while reset is asserted.
  assign stall        = rst_in ? stall_c  : STALL_ALL;
  assign clear_if_id  = rst_in ? clr_if_c : 1'b1;
  assign clear_id_ex  = rst_in ? clr_ex_c : 1'b1;
  assign stall_cycles = stall_cnt_q;
  assign flush_count  = flush_cnt_q;

endmodule

// File: tb/tb_pipeline_ctrl.sv
module tb_pipeline_ctrl;

  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst_in, rdy_in, mem_busy, if_busy, branch_taken, ex_is_load;
  logic [4:0]    ex_rd_addr, id_r1_addr, id_r2_addr;
  logic          id_r1_used, id_r2_used;
  logic [2:0]    stall;
  logic          clear_if_id, clear_id_ex;
  logic [CW-1:0] stall_cycles, flush_count;

  typedef struct {
    logic [2:0]    stall;
    logic          cif;
    logic          cex;
    logic [CW-1:0] sc;
    logic [CW-1:0] fc;
  } exp_t;

  exp_t sb_q[$];
  int   checks = 0;
  int   errors = 0;
  int   vec_idx = 0;

  pipeline_ctrl #(.CNT_W(CW)) dut (
    .clk_in       (clk),
    .rst_in       (rst_in),
    .rdy_in       (rdy_in),
    .mem_busy     (mem_busy),
    .if_busy      (if_busy),
    .branch_taken (branch_taken),
    .ex_is_load   (ex_is_load),
    .ex_rd_addr   (ex_rd_addr),
    .id_r1_addr   (id_r1_addr),
    .id_r2_addr   (id_r2_addr),
    .id_r1_used   (id_r1_used),
    .id_r2_used   (id_r2_used),
    .stall        (stall),
    .clear_if_id  (clear_if_id),
    .clear_id_ex  (clear_id_ex),
    .stall_cycles (stall_cycles),
    .flush_count  (flush_count)
  );

  always #5 clk = ~clk;

  task automatic chk(input string name, input int idx, input logic [31:0] act,
                     input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s vec %0d: got %0h expected %0h", name, idx, act, exp);
    end
  endtask

  // Monitor: every cycle the DUT presents its outputs; compare mid-cycle.
  int mon_idx = 0;
  always @(negedge clk) begin
    if (sb_q.size() > 0) begin
      exp_t e;
      e = sb_q.pop_front();
      chk("stall",        mon_idx, 32'(stall),        32'(e.stall));
      chk("clear_if_id",  mon_idx, 32'(clear_if_id),  32'(e.cif));
      chk("clear_id_ex",  mon_idx, 32'(clear_id_ex),  32'(e.cex));
      chk("stall_cycles", mon_idx, 32'(stall_cycles), 32'(e.sc));
      chk("flush_count",  mon_idx, 32'(flush_count),  32'(e.fc));
      mon_idx++;
    end
  end

  task automatic set_ctl(input logic rst, input logic rdy, input logic mem,
                         input logic ifb, input logic br);
    rst_in = rst; rdy_in = rdy; mem_busy = mem; if_busy = ifb; branch_taken = br;
  endtask

  task automatic set_ld(input logic ld, input logic [4:0] rd, input logic [4:0] r1,
                        input logic [4:0] r2, input logic u1, input logic u2);
    ex_is_load = ld; ex_rd_addr = rd; id_r1_addr = r1; id_r2_addr = r2;
    id_r1_used = u1; id_r2_used = u2;
  endtask

  // Push the expected response for the inputs currently applied, then advance.
  task automatic tick(input logic [2:0] s, input logic cif, input logic cex,
                      input logic [CW-1:0] sc, input logic [CW-1:0] fc);
    exp_t e;
    e.stall = s; e.cif = cif; e.cex = cex; e.sc = sc; e.fc = fc;
    sb_q.push_back(e);
    vec_idx++;
    @(posedge clk);
    #1;
  endtask

  initial begin
    set_ctl(1'b0, 1'b1, 1'b0, 1'b0, 1'b0);
    set_ld(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    @(posedge clk);
    #1;
    // reset state
    tick(3'b111, 1, 1, 0, 0);
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(3'b000, 0, 0, 0, 0);

    // load-use: bubble then exactly one LDUSE cycle
    set_ld(1'b1, 5'd5, 5'd5, 5'd0, 1'b1, 1'b0);
    tick(3'b011, 0, 1, 0, 0);
    tick(3'b000, 0, 0, 1, 0);
    set_ld(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick(3'b000, 0, 0, 1, 0);

    // x0 guard and unused-source match
    set_ld(1'b1, 5'd0, 5'd3, 5'd0, 1'b0, 1'b1);
    tick(3'b000, 0, 0, 1, 0);
    set_ld(1'b1, 5'd7, 5'd1, 5'd7, 1'b0, 1'b0);
    tick(3'b000, 0, 0, 1, 0);
    set_ld(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);

    // taken branch, wrong-path fetch outstanding for 3 cycles
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    tick(3'b000, 1, 1, 1, 0);
    set_ctl(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(3'b001, 1, 0, 1, 1);
    tick(3'b001, 1, 0, 2, 1);
    tick(3'b001, 1, 0, 3, 1);
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(3'b000, 0, 0, 4, 1);

    // reset asserted mid-FLUSH
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    tick(3'b000, 1, 1, 4, 1);
    set_ctl(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(3'b001, 1, 0, 4, 2);
    set_ctl(1'b0, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(3'b111, 1, 1, 0, 0);
    // back in RUN: if_busy alone does not stall
    set_ctl(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(3'b000, 0, 0, 0, 0);

    // branch during mem_busy is deferred to MEMWAIT exit
    set_ctl(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(3'b111, 0, 0, 0, 0);
    set_ctl(1'b1, 1'b1, 1'b1, 1'b0, 1'b1);
    tick(3'b111, 0, 0, 1, 0);
    set_ctl(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    tick(3'b111, 0, 0, 2, 0);
    tick(3'b111, 0, 0, 3, 0);
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(3'b000, 1, 1, 4, 0);
    tick(3'b000, 0, 0, 4, 1);
    tick(3'b000, 0, 0, 4, 1);

    // branch + load-use together: branch wins, FLUSH ignores the hazard
    set_ld(1'b1, 5'd9, 5'd9, 5'd0, 1'b1, 1'b0);
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    tick(3'b000, 1, 1, 4, 1);
    set_ctl(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(3'b001, 1, 0, 4, 2);
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(3'b000, 0, 0, 5, 2);
    set_ld(1'b0, 5'd0, 5'd0, 5'd0, 1'b0, 1'b0);
    tick(3'b000, 0, 0, 5, 2);

    // stall counter saturation
    set_ctl(1'b1, 1'b1, 1'b1, 1'b0, 1'b0);
    for (int i = 0; i < 20; i++)
      tick(3'b111, 0, 0, CW'((5 + i > 15) ? 15 : 5 + i), 2);

    // enter FLUSH, then freeze with rdy_in low: state and counters hold
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b1);
    tick(3'b000, 1, 1, 15, 2);
    set_ctl(1'b1, 1'b0, 1'b0, 1'b1, 1'b1);
    tick(3'b111, 0, 0, 15, 3);
    tick(3'b111, 0, 0, 15, 3);
    tick(3'b111, 0, 0, 15, 3);
    set_ctl(1'b1, 1'b1, 1'b0, 1'b1, 1'b0);
    tick(3'b001, 1, 0, 15, 3);
    set_ctl(1'b1, 1'b1, 1'b0, 1'b0, 1'b0);
    tick(3'b000, 0, 0, 15, 3);
    tick(3'b000, 0, 0, 15, 3);

    @(negedge clk);
    checks++;
    if (sb_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: %0d entries left, expected 0", sb_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

  initial begin
    #20000;
    $display("FAIL timeout: run exceeded time limit");
    $fatal(1, "timeout");
  end

endmodule
